// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the seg7 scan controller: active-low segment codes and digit count.
package seg7_scan_ctrl_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Index n holds the active-low {dp,g,f,e,d,c,b,a} pattern for hex digit n; dp is always off.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_hex_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Latches the CPU seg7 word and scans it as 8 hex digits onto a common-anode display,
// with optional leading-zero blanking. Pin outputs are registered.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 17,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg7_we,
    input  logic [31:0] cpuseg7_data,
    input  logic        blank_lz,
    output logic [7:0]  disp_an,
    output logic [7:0]  disp_seg
);

    localparam int unsigned CNT_W = SCAN_DIV + 3;

    logic [31:0]           data_reg;
    logic [CNT_W-1:0]      scan_cnt;
    logic [2:0]            idx;
    logic [3:0]            nibble;
    logic [7:0]            seg_dec;
    logic [NUM_DIGITS-1:0] lead_zero;
    logic                  blank;
    logic [7:0]            an_d;
    logic [7:0]            seg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= RESET_VALUE;
        end else if (seg7_we) begin
            data_reg <= cpuseg7_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    assign idx    = scan_cnt[CNT_W-1 -: 3];
    assign nibble = data_reg[{idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // lead_zero[i] is set when nibbles 7..i are all zero.
    always_comb begin
        lead_zero = '0;
        lead_zero[NUM_DIGITS-1] = (data_reg[31:28] == 4'h0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lead_zero[i] = lead_zero[i+1] && (data_reg[4*i +: 4] == 4'h0);
        end
    end

    always_comb begin
        blank = blank_lz && (idx != 3'd0) && lead_zero[idx];
        an_d  = ~(8'b1 << idx);
        seg_d = seg_dec;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_an  <= AN_OFF;
            disp_seg <= SEG_OFF;
        end else begin
            disp_an  <= an_d;
            disp_seg <= seg_d;
        end
    end

endmodule
